// File: rtl/nbody_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nbody_pkg
//  Brief    : Shared constants, types and helpers for the N-body pair
//             scheduler (index width, getAccl latencies, FSM states, tags).
//  Revision : 1.0  initial release
// ============================================================================
package nbody_pkg;

   // Body index width; up to 2**IDX_W bodies per pass
   localparam int IDX_W        = 6;
   localparam int N_MAX        = 2 ** IDX_W;

   // getAccl arithmetic stage latencies in cycles
   localparam int MULT_TIME    = 11;
   localparam int ADD_TIME     = 20;
   localparam int INVSQRT_TIME = 27;

   // getAccl input-to-output latency and body-RAM read latency
   localparam int ACCL_LATENCY = 122;
   localparam int RAM_LAT      = 1;

   // Address issue to ax/ay result, in cycles
   localparam int PIPE_DLY     = ACCL_LATENCY + RAM_LAT;

   typedef logic [IDX_W-1:0] idx_t;
   typedef logic [IDX_W:0]   cnt_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } sched_state_t;

   typedef struct packed {
      logic valid;
      idx_t i;
      logic first;
      logic last;
   } pair_tag_t;

   // A pass needs at least two bodies and fits in the body RAM
   function automatic logic count_legal(input cnt_t n);
      return (n >= cnt_t'(2)) && (n <= cnt_t'(N_MAX));
   endfunction

endpackage
`default_nettype wire

// File: rtl/nbody_pair_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : nbody_pair_scheduler_if
//  Brief    : Control, body-RAM address and result-tag signals between a
//             host/accumulator (master) and the pair scheduler (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface nbody_pair_scheduler_if;
   import nbody_pkg::*;

   logic start;
   cnt_t num_bodies;
   logic pause;
   idx_t rd_i_addr;
   idx_t rd_j_addr;
   logic issue_valid;
   logic busy;
   logic out_valid;
   idx_t out_i;
   logic out_first;
   logic out_last;
   logic done;
   logic cfg_err;

   modport master (
      output start, num_bodies, pause,
      input  rd_i_addr, rd_j_addr, issue_valid, busy,
      input  out_valid, out_i, out_first, out_last, done, cfg_err
   );

   modport slave (
      input  start, num_bodies, pause,
      output rd_i_addr, rd_j_addr, issue_valid, busy,
      output out_valid, out_i, out_first, out_last, done, cfg_err
   );

endinterface
`default_nettype wire

// File: rtl/nbody_pair_scheduler_tag_delay_line.sv
`default_nettype none
// ============================================================================
//  Module   : tag_delay_line
//  Brief    : DEPTH-stage shift register of pair tags with an occupancy
//             counter; any_valid_o reports whether a valid tag remains in
//             the line once the current cycle's shift has taken place.
//  Revision : 1.0  initial release
// ============================================================================
module tag_delay_line
   import nbody_pkg::*;
#(
   parameter int DEPTH = PIPE_DLY
) (
   input  logic      clk,
   input  logic      rst,
   input  pair_tag_t tag_i,
   output pair_tag_t tag_o,
   output logic      any_valid_o
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   pair_tag_t        stage_q [DEPTH];
   logic [CNT_W-1:0] occ_q;
   logic [CNT_W-1:0] occ_d;

   assign tag_o = stage_q[DEPTH-1];

   // Shift tags one stage per cycle; reset wipes every stage
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            stage_q[k] <= '0;
         end
      end else begin
         stage_q[0] <= tag_i;
         for (int k = 1; k < DEPTH; k++) begin
            stage_q[k] <= stage_q[k-1];
         end
      end
   end

   // Next occupancy: one in, one out, or balanced
   always_comb begin
      occ_d = occ_q;
      if (tag_i.valid && !tag_o.valid) begin
         occ_d = occ_q + 1'b1;
      end else if (!tag_i.valid && tag_o.valid) begin
         occ_d = occ_q - 1'b1;
      end
   end

   // Occupancy register
   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   // Looking at the post-shift count lets DRAIN exit right as the last
   // result leaves, so done lands on the cycle after the final out_valid.
   assign any_valid_o = (occ_d != '0);

endmodule
`default_nettype wire

// File: rtl/nbody_pair_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : nbody_pair_scheduler
//  Brief    : Streams every (i, j != i) body pair into the pipelined getAccl
//             unit at one pair per cycle and delivers a matching tag
//             (target, first, last) alongside each ax/ay result.
//  Revision : 1.0  initial release
// ============================================================================
module nbody_pair_scheduler
   import nbody_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   nbody_pair_scheduler_if.slave bus
);

   sched_state_t state_q, state_d;
   idx_t         i_q, i_d;
   idx_t         j_q, j_d;
   cnt_t         n_q, n_d;
   logic         err_q, err_d;

   logic         issue;
   logic         last_pair;
   logic         tag_first;
   logic         tag_last;
   cnt_t         i_ext;
   cnt_t         j_ext;
   cnt_t         n_m1;
   cnt_t         n_m2;
   cnt_t         j_inc;
   cnt_t         j_cand;
   idx_t         i_next;

   pair_tag_t    tag_in;
   pair_tag_t    tag_out;
   logic         line_busy;

   assign i_ext = {1'b0, i_q};
   assign j_ext = {1'b0, j_q};
   assign n_m1  = n_q - 1'b1;
   assign n_m2  = n_q - 2'd2;

   // Next source index above j, stepping over the target itself
   assign j_inc  = j_ext + 1'b1;
   assign j_cand = (j_inc == i_ext) ? (j_inc + 1'b1) : j_inc;
   assign i_next = i_q + 1'b1;

   assign last_pair = (i_ext == n_m1) && (j_ext == n_m2);
   assign tag_first = (i_q == '0) ? (j_q == idx_t'(1)) : (j_q == '0);
   assign tag_last  = (i_ext == n_m1) ? (j_ext == n_m2) : (j_ext == n_m1);

   // Next-state, counter advance and issue decision
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      n_d     = n_q;
      err_d   = err_q;
      issue   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (count_legal(bus.num_bodies)) begin
                  n_d     = bus.num_bodies;
                  i_d     = '0;
                  j_d     = idx_t'(1);
                  err_d   = 1'b0;
                  state_d = ISSUE;
               end else begin
                  err_d   = 1'b1;
                  state_d = FIN;
               end
            end
         end
         ISSUE: begin
            if (!bus.pause) begin
               issue = 1'b1;
               if (last_pair) begin
                  state_d = DRAIN;
               end else if (j_cand >= n_q) begin
                  i_d = i_next;
                  j_d = (i_next == '0) ? idx_t'(1) : '0;
               end else begin
                  j_d = j_cand[IDX_W-1:0];
               end
            end
         end
         DRAIN: begin
            if (!line_busy) begin
               state_d = FIN;
            end
         end
         FIN: begin
            err_d   = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and pair-counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         i_q     <= '0;
         j_q     <= '0;
         n_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         n_q     <= n_d;
         err_q   <= err_d;
      end
   end

   // Tag fields are zeroed on bubbles so idle result slots read all-zero
   assign tag_in.valid = issue;
   assign tag_in.i     = issue ? i_q : '0;
   assign tag_in.first = issue & tag_first;
   assign tag_in.last  = issue & tag_last;

   tag_delay_line #(
      .DEPTH (PIPE_DLY)
   ) u_tag_delay_line (
      .clk         (clk),
      .rst         (rst),
      .tag_i       (tag_in),
      .tag_o       (tag_out),
      .any_valid_o (line_busy)
   );

   assign bus.rd_i_addr   = i_q;
   assign bus.rd_j_addr   = j_q;
   assign bus.issue_valid = issue;
   assign bus.busy        = (state_q == ISSUE) || (state_q == DRAIN);
   assign bus.done        = (state_q == FIN);
   assign bus.cfg_err     = (state_q == FIN) && err_q;
   assign bus.out_valid   = tag_out.valid;
   assign bus.out_i       = tag_out.i;
   assign bus.out_first   = tag_out.first;
   assign bus.out_last    = tag_out.last;

endmodule
`default_nettype wire

// File: tb/tb_nbody_pair_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nbody_pair_scheduler
//  Brief    : Directed self-checking bench for nbody_pair_scheduler.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nbody_pair_scheduler;
   import nbody_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   nbody_pair_scheduler_if bus ();

   nbody_pair_scheduler dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int tests = 0;
   int fails = 0;

   typedef struct {
      int cyc;
      int i;
      bit f;
      bit l;
   } exp_t;

   exp_t expq[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // One legal pass; cycle c=1 is the first cycle after the start edge.
   // Pause is held high for cycles pstart..pstart+plen-1.
   task automatic run_pass(input int n, input int pstart, input int plen, input int exp_done_cyc);
      int   total;
      int   mi;
      int   mj;
      int   issued;
      int   last_issue;
      int   done_cyc;
      int   results;
      int   per_i[N_MAX];
      bit   pz;
      bit   exp_iv;
      bit   exp_done;
      bit   exp_busy;
      exp_t e;
      total      = n * (n - 1);
      mi         = 0;
      mj         = 1;
      issued     = 0;
      last_issue = -1;
      done_cyc   = -1;
      results    = 0;
      for (int k = 0; k < N_MAX; k++) per_i[k] = 0;
      expq.delete();
      @(posedge clk); #1;
      bus.start      = 1'b1;
      bus.num_bodies = cnt_t'(n);
      bus.pause      = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int c = 1; c <= total + plen + PIPE_DLY + 3; c++) begin
         pz        = (c >= pstart) && (c < pstart + plen);
         bus.pause = pz;
         @(negedge clk);
         exp_iv = !pz && (issued < total);
         check("issue_valid", 32'(bus.issue_valid), 32'(exp_iv));
         if (exp_iv) begin
            check("rd_i_addr", 32'(bus.rd_i_addr), 32'(mi));
            check("rd_j_addr", 32'(bus.rd_j_addr), 32'(mj));
            e.cyc = c + PIPE_DLY;
            e.i   = mi;
            e.f   = (mj == ((mi == 0) ? 1 : 0));
            e.l   = (mj == ((mi == n - 1) ? n - 2 : n - 1));
            expq.push_back(e);
            issued++;
            if (issued == total) last_issue = c;
            mj++;
            if (mj == mi) mj++;
            if (mj >= n) begin
               mi++;
               mj = 0;
            end
         end
         if ((expq.size() > 0) && (expq[0].cyc == c)) begin
            e = expq.pop_front();
            check("out_valid", 32'(bus.out_valid), 32'd1);
            check("out_i", 32'(bus.out_i), 32'(e.i));
            check("out_first", 32'(bus.out_first), 32'(e.f));
            check("out_last", 32'(bus.out_last), 32'(e.l));
            if (bus.out_valid === 1'b1) begin
               per_i[int'(bus.out_i)]++;
               results++;
            end
         end else begin
            check("out_valid_idle", 32'(bus.out_valid), 32'd0);
         end
         exp_done = (last_issue > 0) && (c == last_issue + PIPE_DLY + 1);
         exp_busy = (last_issue < 0) || (c <= last_issue + PIPE_DLY);
         check("done", 32'(bus.done), 32'(exp_done));
         check("busy", 32'(bus.busy), 32'(exp_busy));
         check("cfg_err", 32'(bus.cfg_err), 32'd0);
         if (bus.done === 1'b1) done_cyc = c;
         @(posedge clk); #1;
      end
      bus.pause = 1'b0;
      check("done_cycle", 32'(done_cyc), 32'(exp_done_cyc));
      check("result_count", 32'(results), 32'(total));
      for (int k = 0; k < n; k++) begin
         check("results_per_i", 32'(per_i[k]), 32'(n - 1));
      end
   endtask

   // Illegal body count: done+cfg_err in the cycle after the start edge
   task automatic run_illegal(input int n);
      @(posedge clk); #1;
      bus.start      = 1'b1;
      bus.num_bodies = cnt_t'(n);
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk);
      check("ill_done", 32'(bus.done), 32'd1);
      check("ill_cfg_err", 32'(bus.cfg_err), 32'd1);
      check("ill_busy", 32'(bus.busy), 32'd0);
      check("ill_issue", 32'(bus.issue_valid), 32'd0);
      check("ill_out", 32'(bus.out_valid), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("ill_done_after", 32'(bus.done), 32'd0);
      check("ill_cfg_after", 32'(bus.cfg_err), 32'd0);
      check("ill_issue_after", 32'(bus.issue_valid), 32'd0);
   endtask

   int stray;

   initial begin
      rst            = 1'b1;
      bus.start      = 1'b0;
      bus.num_bodies = '0;
      bus.pause      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_issue", 32'(bus.issue_valid), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_cfg_err", 32'(bus.cfg_err), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_rd_i", 32'(bus.rd_i_addr), 32'd0);
      check("rst_rd_j", 32'(bus.rd_j_addr), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // N=3: issues T0+1..T0+6, results T0+124..T0+129, done T0+130
      run_pass(3, 0, 0, 130);
      // N=2: two results, each both first and last; done T0+2+124
      run_pass(2, 0, 0, 126);
      // N=3 with pause on issue cycles 3..5: done slips by 3
      run_pass(3, 3, 3, 133);

      run_illegal(1);
      run_illegal(0);
      run_illegal(N_MAX + 1);

      // Reset in the third issue cycle of an N=4 pass
      @(posedge clk); #1;
      bus.start      = 1'b1;
      bus.num_bodies = cnt_t'(4);
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk);
      check("rp_issue1", 32'(bus.issue_valid), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("rp_issue2", 32'(bus.issue_valid), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("rp_issue3", 32'(bus.issue_valid), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rp_issue", 32'(bus.issue_valid), 32'd0);
      check("rp_busy", 32'(bus.busy), 32'd0);
      check("rp_done", 32'(bus.done), 32'd0);
      check("rp_out_valid", 32'(bus.out_valid), 32'd0);
      check("rp_rd_i", 32'(bus.rd_i_addr), 32'd0);
      check("rp_rd_j", 32'(bus.rd_j_addr), 32'd0);
      stray = 0;
      for (int c = 0; c < PIPE_DLY + 10; c++) begin
         @(negedge clk);
         if ((bus.out_valid !== 1'b0) || (bus.done !== 1'b0) || (bus.issue_valid !== 1'b0)) stray++;
      end
      check("rp_no_activity", 32'(stray), 32'd0);
      run_pass(4, 0, 0, 136);

      // Full-size pass: 4032 issues, done 124 cycles after the last one
      run_pass(64, 0, 0, 4156);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
